// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART program loader.
// Build option: LOADER_CHECKSUM_EN adds the CHK loader state.
package uart_loader_pkg;
    localparam int HDR_BYTES      = 3;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, CHK} ld_state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} ld_state_t;
`endif
endpackage

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: memory upgrade write port.
// Signals: upg_wen write strobe, upg_sel target (0 imem / 1 dmem),
// upg_adr word address, upg_dat write data.
// master = loader side (drives), slave = memory side (receives).
interface uart_prog_loader_if;
    logic        upg_wen;
    logic        upg_sel;
    logic [13:0] upg_adr;
    logic [31:0] upg_dat;
    modport master (output upg_wen, upg_sel, upg_adr, upg_dat);
    modport slave  (input  upg_wen, upg_sel, upg_adr, upg_dat);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver.
// Ports: clock, rst (async active-low), rx serial line (idle high);
// rx_data received byte, byte_valid one-cycle strobe with a good stop bit,
// frame_err_pulse one-cycle strobe when the stop bit is sampled low.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err_pulse
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    logic [2:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;

    // sync[1:0] is the two-flop synchronizer; sync[2] is the previous
    // synchronized level so a true falling edge is required to start.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state           <= RX_IDLE;
            sync            <= 3'b111;
            cnt             <= '0;
            bit_idx         <= '0;
            sh              <= '0;
            rx_data         <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            sync            <= {sync[1:0], rx};
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (sync[2] && !sync[1]) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        state   <= sync[1] ? RX_IDLE : RX_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        sh      <= {sync[1], sh[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        state <= RX_IDLE;
                        cnt   <= '0;
                        if (sync[1]) begin
                            byte_valid <= 1'b1;
                            rx_data    <= sh;
                        end else frame_err_pulse <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: loads a program image over UART into instruction/data memory.
// Ports: clock, rst (async active-low), uart_rx serial in, start_load arm pulse;
// upg (master) memory write port; cpu_hold CPU reset while loading;
// upg_done sticky success; frame_err sticky stop-bit error;
// chk_err sticky checksum mismatch (only with LOADER_CHECKSUM_EN).
// Frame: byte0[0] = target, bytes1-2 = word count N (LE), then N LE words,
// then (LOADER_CHECKSUM_EN) one XOR checksum byte over all preceding bytes.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int MEM_WORDS    = 16384
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       uart_rx,
    input  logic                       start_load,
    uart_prog_loader_if.master         upg,
    output logic                       cpu_hold,
    output logic                       upg_done,
`ifdef LOADER_CHECKSUM_EN
    output logic                       chk_err,
`endif
    output logic                       frame_err
);
`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t LAST_ST = CHK;
`else
    localparam ld_state_t LAST_ST = DONE;
`endif

    ld_state_t   state;
    logic [1:0]  hdr_cnt;
    logic [1:0]  byte_cnt;
    logic [15:0] n;
    logic [15:0] word_cnt;
    logic [23:0] asm_q;
    logic [7:0]  rx_data;
    logic        byte_valid;
    logic        fe_pulse;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock          (clock),
        .rst            (rst),
        .rx             (uart_rx),
        .rx_data        (rx_data),
        .byte_valid     (byte_valid),
        .frame_err_pulse(fe_pulse)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hdr_cnt     <= '0;
            byte_cnt    <= '0;
            n           <= '0;
            word_cnt    <= '0;
            asm_q       <= '0;
            upg.upg_wen <= 1'b0;
            upg.upg_sel <= 1'b0;
            upg.upg_adr <= '0;
            upg.upg_dat <= '0;
            cpu_hold    <= 1'b0;
            upg_done    <= 1'b0;
            frame_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk         <= '0;
            chk_err     <= 1'b0;
`endif
        end else begin
            upg.upg_wen <= 1'b0;
            frame_err   <= frame_err | fe_pulse;
            // address advances only after a real write, so skipped words never wrap it
            if (upg.upg_wen) upg.upg_adr <= upg.upg_adr + 14'd1;
            if (start_load) begin
                state       <= HDR;
                hdr_cnt     <= '0;
                byte_cnt    <= '0;
                word_cnt    <= '0;
                upg.upg_adr <= '0;
                cpu_hold    <= 1'b1;
                upg_done    <= 1'b0;
                frame_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                chk         <= '0;
                chk_err     <= 1'b0;
`endif
            end else if (byte_valid) begin
                case (state)
                    HDR: begin
                        hdr_cnt <= hdr_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk     <= chk ^ rx_data;
`endif
                        if (hdr_cnt == 2'd0) upg.upg_sel <= rx_data[0];
                        else if (hdr_cnt == 2'd1) n[7:0] <= rx_data;
                        else if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                            n[15:8] <= rx_data;
                            if ({rx_data, n[7:0]} == 16'd0) begin
                                state <= LAST_ST;
                                if (LAST_ST == DONE) begin
                                    upg_done <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end
                            end else state <= DATA;
                        end
                    end
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk      <= chk ^ rx_data;
`endif
                        if (byte_cnt != 2'(BYTES_PER_WORD - 1)) asm_q <= {rx_data, asm_q[23:8]};
                        else begin
                            upg.upg_dat <= {rx_data, asm_q};
                            upg.upg_wen <= 32'(word_cnt) < MEM_WORDS;
                            word_cnt    <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == n) begin
                                state <= LAST_ST;
                                if (LAST_ST == DONE) begin
                                    upg_done <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHK: begin
                        state    <= (rx_data == chk) ? DONE : IDLE;
                        upg_done <= rx_data == chk;
                        chk_err  <= rx_data != chk;
                        cpu_hold <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: self-checking bench for uart_prog_loader (CLKS_PER_BIT=16, MEM_WORDS=2).
// Honours LOADER_CHECKSUM_EN: frames then carry a trailing XOR byte.
module tb_uart_prog_loader;
    localparam int CPB = 16;
    localparam int MW  = 2;

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic start_load = 1'b0;
    logic cpu_hold, upg_done, frame_err;
`ifdef LOADER_CHECKSUM_EN
    logic chk_err;
`endif

    uart_prog_loader_if mif();

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
        .clock     (clock),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .start_load(start_load),
        .upg       (mif),
        .cpu_hold  (cpu_hold),
        .upg_done  (upg_done),
`ifdef LOADER_CHECKSUM_EN
        .chk_err   (chk_err),
`endif
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        sel;
        logic [13:0] adr;
        logic [31:0] dat;
    } wr_t;
    wr_t wq[$];

    always @(negedge clock) if (mif.upg_wen) wq.push_back('{mif.upg_sel, mif.upg_adr, mif.upg_dat});

    typedef struct {
        logic [7:0]  hdr0;
        int          n;
        logic [31:0] w [3];
        int          exp_wr;
        logic        exp_sel;
    } vec_t;
    vec_t vec [5];

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] xsum;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) xsum = xsum ^ b;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clock);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        @(negedge clock);
        start_load = 1'b0;
        xsum = 8'h00;
        wq.delete();
    endtask

    task automatic send_hdr(input logic [7:0] h0, input logic [15:0] nw);
        send_byte(h0, 1'b1);
        send_byte(nw[7:0], 1'b1);
        send_byte(nw[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic send_chk(input logic [7:0] bad);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = xsum ^ bad;
        send_byte(c, 1'b1);
`else
        if (bad != 8'h00) $display("note: checksum byte not used in this build");
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'h00, 2, '{32'h12345678, 32'hDEADBEEF, 32'h0}, 2, 1'b0};
        vec[1] = '{8'h01, 0, '{32'h0, 32'h0, 32'h0}, 0, 1'b1};
        vec[2] = '{8'h01, 1, '{32'hA5A50F0F, 32'h0, 32'h0}, 1, 1'b1};
        vec[3] = '{8'h00, 3, '{32'h11111111, 32'h22222222, 32'h33333333}, 2, 1'b0};
        vec[4] = '{8'hFE, 1, '{32'hCAFEBABE, 32'h0, 32'h0}, 1, 1'b0};

        repeat (3) @(negedge clock);
        check("rst_wen", {31'd0, mif.upg_wen}, 0);
        check("rst_sel", {31'd0, mif.upg_sel}, 0);
        check("rst_adr", {18'd0, mif.upg_adr}, 0);
        check("rst_dat", mif.upg_dat, 0);
        check("rst_hold", {31'd0, cpu_hold}, 0);
        check("rst_done", {31'd0, upg_done}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            pulse_start();
            check($sformatf("v%0d_hold_on", v), {31'd0, cpu_hold}, 1);
            check($sformatf("v%0d_done_clr", v), {31'd0, upg_done}, 0);
            send_hdr(vec[v].hdr0, 16'(vec[v].n));
            for (int j = 0; j < vec[v].n; j++) send_word(vec[v].w[j]);
            send_chk(8'h00);
            repeat (2) @(negedge clock);
            check($sformatf("v%0d_nwr", v), wq.size(), vec[v].exp_wr);
            for (int j = 0; j < vec[v].exp_wr; j++) begin
                if (j < wq.size()) begin
                    check($sformatf("v%0d_adr%0d", v, j), {18'd0, wq[j].adr}, j);
                    check($sformatf("v%0d_dat%0d", v, j), wq[j].dat, vec[v].w[j]);
                    check($sformatf("v%0d_sel%0d", v, j), {31'd0, wq[j].sel}, {31'd0, vec[v].exp_sel});
                end
            end
            check($sformatf("v%0d_adr_end", v), {18'd0, mif.upg_adr}, vec[v].exp_wr);
            check($sformatf("v%0d_done", v), {31'd0, upg_done}, 1);
            check($sformatf("v%0d_hold_off", v), {31'd0, cpu_hold}, 0);
            check($sformatf("v%0d_ferr", v), {31'd0, frame_err}, 0);
`ifdef LOADER_CHECKSUM_EN
            check($sformatf("v%0d_chkerr", v), {31'd0, chk_err}, 0);
`endif
        end

        // N = 0: done is already set right at the end of the last stop bit
        pulse_start();
        send_hdr(8'h01, 16'd0);
        send_chk(8'h00);
        check("n0_done_prompt", {31'd0, upg_done}, 1);
        check("n0_nwr", wq.size(), 0);

        // stop-bit error mid-word: byte dropped, assembly continues
        pulse_start();
        send_hdr(8'h00, 16'd1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h99, 1'b0);
        check("fe_set", {31'd0, frame_err}, 1);
        check("fe_nwr_mid", wq.size(), 0);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_chk(8'h00);
        repeat (2) @(negedge clock);
        check("fe_nwr", wq.size(), 1);
        if (wq.size() > 0) check("fe_dat", wq[0].dat, 32'h12345678);
        check("fe_sticky", {31'd0, frame_err}, 1);
        check("fe_done", {31'd0, upg_done}, 1);

        // reset mid-word, then bytes in IDLE are ignored, then a fresh load
        pulse_start();
        send_hdr(8'h01, 16'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst = 1'b0;
        #1;
        check("mr_hold", {31'd0, cpu_hold}, 0);
        check("mr_sel", {31'd0, mif.upg_sel}, 0);
        check("mr_dat", mif.upg_dat, 0);
        check("mr_adr", {18'd0, mif.upg_adr}, 0);
        check("mr_wen", {31'd0, mif.upg_wen}, 0);
        check("mr_done", {31'd0, upg_done}, 0);
        check("mr_ferr", {31'd0, frame_err}, 0);
        repeat (3) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        send_word(32'h66554433);
        repeat (2) @(negedge clock);
        check("idle_nwr", wq.size(), 0);
        check("idle_hold", {31'd0, cpu_hold}, 0);
        // short low glitch must be rejected before the real frame
        uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        pulse_start();
        send_hdr(8'h00, 16'd1);
        send_word(32'h12345678);
        send_chk(8'h00);
        repeat (2) @(negedge clock);
        check("mr2_nwr", wq.size(), 1);
        if (wq.size() > 0) begin
            check("mr2_adr", {18'd0, wq[0].adr}, 0);
            check("mr2_dat", wq[0].dat, 32'h12345678);
        end
        check("mr2_done", {31'd0, upg_done}, 1);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send_hdr(8'h00, 16'd1);
        send_word(32'h0BADF00D);
        send_chk(8'h01);
        repeat (2) @(negedge clock);
        check("ck_err", {31'd0, chk_err}, 1);
        check("ck_done", {31'd0, upg_done}, 0);
        check("ck_hold", {31'd0, cpu_hold}, 0);
        check("ck_nwr", wq.size(), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, giving clock cycles per UART bit (10 MHz / 115200 baud).
REQ-002 SHALL have parameter MEM_WORDS, default 16384, giving the depth of each target memory in 32-bit words.
REQ-003 SHALL have port clock, input, 1, the single clock shared with the CPU uart_clk domain.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port uart_rx, input, 1, serial data line (8N1, idle high).
REQ-006 SHALL have port start_load, input, 1, debounced one-cycle pulse that arms a new load.
REQ-007 SHALL have port upg_wen, output, 1, one-cycle write strobe to the memory.
REQ-008 SHALL have port upg_sel, output, 1, memory target (0 = instruction memory, 1 = data memory).
REQ-009 SHALL have port upg_adr, output, 14, word address.
REQ-010 SHALL have port upg_dat, output, 32, write data.
REQ-011 SHALL have port cpu_hold, output, 1, which holds the CPU in reset while high.
REQ-012 SHALL have port upg_done, output, 1, sticky flag set when a load completes successfully.
REQ-013 SHALL have port frame_err, output, 1, sticky flag set on a stop-bit error.

Function
REQ-014 SHALL pass uart_rx through a two-flop synchronizer before any sampling.
REQ-015 Receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
- Falling edge in RX_IDLE -> RX_START.
- RX_START re-checks the line low at CLKS_PER_BIT/2; high returns to RX_IDLE as a glitch.
- RX_DATA samples 8 bits LSB-first, each at bit centre.
- RX_STOP samples the stop bit.
REQ-016 A stop bit sampled as 0 SHALL discard the byte and set frame_err; a stop bit of 1 SHALL emit a one-cycle byte_valid.
REQ-017 Loader FSM SHALL have states IDLE, HDR, DATA, DONE; start_load in any state SHALL go to HDR and clear upg_done, frame_err and the byte counters.
REQ-018 HDR SHALL take 3 bytes: byte0[0] selects upg_sel, then bytes1-2 form a 16-bit word count N (little-endian).
REQ-019 N = 0 SHALL go directly from HDR to DONE, with no write.
REQ-020 DATA SHALL assemble 4 bytes per word little-endian (first byte is [7:0]) and assert upg_wen on the cycle after the 4th byte_valid.
REQ-021 upg_adr SHALL start at 0 and increment by 1 after each write.
REQ-022 Words with index >= MEM_WORDS SHALL be counted but not written (upg_wen stays low); the address SHALL NOT wrap.
REQ-023 After the N-th word the loader SHALL enter DONE, set upg_done and drop cpu_hold.
REQ-024 cpu_hold SHALL be high in HDR and DATA, and low in IDLE and DONE.
REQ-025 Bytes arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-026 While rst = 0, the module SHALL hold both FSMs in RX_IDLE/IDLE and drive all outputs to 0 (upg_wen, upg_sel, upg_adr, upg_dat, cpu_hold, upg_done, frame_err).
REQ-027 Reset mid-load SHALL abandon the partial word with no write; a new start_load SHALL be required before loading resumes.

Configuration
REQ-028 With macro LOADER_CHECKSUM_EN defined, the loader SHALL expect one extra byte after the last word, equal to the XOR of all header and data bytes.
- Match -> DONE.
- Mismatch -> IDLE with cpu_hold low, upg_done low, and a sticky chk_err output set.
REQ-029 With LOADER_CHECKSUM_EN undefined, there SHALL be no checksum byte and no chk_err port, and DONE SHALL follow the N-th word.

Structure
REQ-030 Package uart_loader_pkg SHALL hold the rx_state_t and ld_state_t enums, HDR_BYTES = 3 and BYTES_PER_WORD = 4.
REQ-031 Sub-module uart_rx_byte SHALL contain the synchronizer, the receiver FSM and the bit-timing counter, and output byte/byte_valid/frame_err_pulse.

Verification
REQ-032 Reset then start_load, header 00 02 00, bytes 78 56 34 12 EF BE AD DE -> upg_wen at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF, sel = 0; upg_done = 1; cpu_hold falls.
REQ-033 Header 01 00 00 -> DONE with no upg_wen, and upg_done = 1 within 1 cycle of the last stop bit.
REQ-034 Byte sent with stop bit 0 -> frame_err = 1, byte not counted; next valid bytes continue assembly.
REQ-035 rst pulsed low after 2 data bytes -> all outputs 0 immediately; after start_load and a full 1-word frame, data is written to addr 0.
REQ-036 MEM_WORDS = 2, N = 3 -> exactly 2 writes (addr 0, 1), then upg_done = 1.
REQ-037 LOADER_CHECKSUM_EN defined, 1-word frame with wrong XOR -> chk_err = 1, upg_done = 0, cpu_hold = 0.
